// File: rtl/wirelog_pkg.sv
// Shared helpers for the wire/lamp input side of the gate array.
// Holds the default counter width plus popcount and saturating-add helpers.
package wirelog_pkg;

    localparam int DEFAULT_CNT_W = 8;
    localparam int MAX_LAMPS     = 64;

    typedef enum logic {
        EV_IDLE    = 1'b0,
        EV_PENDING = 1'b1
    } ev_state_t;

    // Callers zero-extend their vector to MAX_LAMPS bits.
    function automatic logic [31:0] popcount(input logic [MAX_LAMPS-1:0] vec);
        logic [31:0] total;
        total = '0;
        for (int i = 0; i < MAX_LAMPS; i++) begin
            total = total + {31'd0, vec[i]};
        end
        return total;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                            input logic [31:0] inc,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_val;
        max_val = (width >= 32) ? 33'h0_FFFF_FFFF : ((33'd1 << width) - 33'd1);
        sum     = {1'b0, cnt} + {1'b0, inc};
        if (sum > max_val) begin
            sum = max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/wire_hit_tracker.sv
// Tracks which wires were already hit in the current logic step and splits
// incoming trigger pulses into accepted toggles and dropped repeat hits.
module wire_hit_tracker
    import wirelog_pkg::*;
#(
    parameter int LAMP_COUNT = 2
) (
    input  logic                  clk,
    input  logic                  logic_reset_n,
    input  logic                  step_start,
    input  logic [LAMP_COUNT-1:0] trig,
    output logic [LAMP_COUNT-1:0] hit_mask,
    output logic [LAMP_COUNT-1:0] acc,
    output logic [LAMP_COUNT-1:0] drop
);

    logic [LAMP_COUNT-1:0] hit_eff;

    // A new step discards the old mask before the same-cycle trig is judged.
    always_comb begin
        hit_eff = step_start ? '0 : hit_mask;
        acc     = trig & ~hit_eff;
        drop    = trig &  hit_eff;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge logic_reset_n) begin
        if (!logic_reset_n) begin
            hit_mask <= '0;
        end else begin
            hit_mask <= hit_eff | trig;
        end
    end

endmodule

// File: rtl/lamp_trigger_bank.sv
// Converts wire trigger pulses into lamp states for the gate array and
// notifies the gate evaluator of changes through a coalescing valid/ready flag.
module lamp_trigger_bank
    import wirelog_pkg::*;
#(
    parameter int                  LAMP_COUNT = 2,
    parameter logic [LAMP_COUNT-1:0] LAMP_INIT = '0,
    parameter int                  CNT_W      = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  logic_reset_n,
    input  logic                  step_start,
    input  logic [LAMP_COUNT-1:0] trig,
    output logic [LAMP_COUNT-1:0] lamp_state,
    output logic [LAMP_COUNT-1:0] hit_mask,
    output logic                  eval_valid,
    input  logic                  eval_ready,
    output logic [CNT_W-1:0]      drop_cnt
);

    logic [LAMP_COUNT-1:0] acc;
    logic [LAMP_COUNT-1:0] drop;
    logic                  any_acc;
    logic [31:0]           drop_inc;
    logic [31:0]           drop_sum;
    ev_state_t             ev_state;
    ev_state_t             ev_state_nxt;

    wire_hit_tracker #(
        .LAMP_COUNT (LAMP_COUNT)
    ) u_tracker (
        .clk           (clk),
        .logic_reset_n (logic_reset_n),
        .step_start    (step_start),
        .trig          (trig),
        .hit_mask      (hit_mask),
        .acc           (acc),
        .drop          (drop)
    );

    assign any_acc  = |acc;
    assign drop_inc = popcount(MAX_LAMPS'(drop));
    assign drop_sum = sat_add(32'(drop_cnt), drop_inc, CNT_W);

    always_ff @(posedge clk or negedge logic_reset_n) begin
        if (!logic_reset_n) begin
            lamp_state <= LAMP_INIT;
            drop_cnt   <= '0;
        end else begin
            lamp_state <= lamp_state ^ acc;
            drop_cnt   <= drop_sum[CNT_W-1:0];
        end
    end

    // New toggles win over a same-cycle handshake; later changes coalesce into
    // a pending notification, with no compare-and-cancel.
    // NOTE: ev_state_nxt gets a default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        ev_state_nxt = ev_state;
        if (any_acc) begin
            ev_state_nxt = EV_PENDING;
        end else if (ev_state == EV_PENDING && eval_ready) begin
            ev_state_nxt = EV_IDLE;
        end
    end

    always_ff @(posedge clk or negedge logic_reset_n) begin
        if (!logic_reset_n) begin
            ev_state <= EV_IDLE;
        end else begin
            ev_state <= ev_state_nxt;
        end
    end

    assign eval_valid = (ev_state == EV_PENDING);

endmodule

// File: tb/tb_lamp_trigger_bank.sv
// Directed bench for lamp_trigger_bank with LAMP_COUNT=4, CNT_W=4.
module tb_lamp_trigger_bank;

    localparam int LC = 4;
    localparam int CW = 4;

    logic          clk;
    logic          logic_reset_n;
    logic          step_start;
    logic [LC-1:0] trig;
    logic [LC-1:0] lamp_state;
    logic [LC-1:0] hit_mask;
    logic          eval_valid;
    logic          eval_ready;
    logic [CW-1:0] drop_cnt;

    int passed = 0;
    int total  = 0;

    lamp_trigger_bank #(
        .LAMP_COUNT (LC),
        .LAMP_INIT  (4'b0000),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .logic_reset_n (logic_reset_n),
        .step_start    (step_start),
        .trig          (trig),
        .lamp_state    (lamp_state),
        .hit_mask      (hit_mask),
        .eval_valid    (eval_valid),
        .eval_ready    (eval_ready),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs at the falling edge, let one rising edge capture them,
    // then leave the outputs settled 1 time unit after that edge.
    task automatic cycle(input logic ss, input logic [LC-1:0] tr, input logic rdy);
        @(negedge clk);
        step_start = ss;
        trig       = tr;
        eval_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic_reset_n = 1'b0;
        step_start    = 1'b0;
        trig          = '0;
        eval_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({lamp_state, hit_mask, eval_valid, drop_cnt} !== 13'b0000_0000_0_0000)
            $display("FAIL reset: got lamp=%b hit=%b ev=%b drop=%0d, want 0000 0000 0 0",
                     lamp_state, hit_mask, eval_valid, drop_cnt);
        else passed++;
        @(negedge clk);
        logic_reset_n = 1'b1;
    endtask

    task automatic test_first_step();
        cycle(1'b1, 4'b0101, 1'b0);
        total++;
        if ({lamp_state, hit_mask, eval_valid, drop_cnt} !== {4'b0101, 4'b0101, 1'b1, 4'd0})
            $display("FAIL first_step: got lamp=%b hit=%b ev=%b drop=%0d, want 0101 0101 1 0",
                     lamp_state, hit_mask, eval_valid, drop_cnt);
        else passed++;
    endtask

    task automatic test_repeat_hit();
        // hit_eff=0101: bit1 accepted, bit2 dropped
        cycle(1'b0, 4'b0110, 1'b0);
        total++;
        if ({lamp_state, hit_mask, eval_valid, drop_cnt} !== {4'b0111, 4'b0111, 1'b1, 4'd1})
            $display("FAIL repeat_hit: got lamp=%b hit=%b ev=%b drop=%0d, want 0111 0111 1 1",
                     lamp_state, hit_mask, eval_valid, drop_cnt);
        else passed++;
    endtask

    task automatic test_step_with_trig();
        cycle(1'b1, 4'b0001, 1'b0);
        total++;
        if ({lamp_state, hit_mask, eval_valid, drop_cnt} !== {4'b0110, 4'b0001, 1'b1, 4'd1})
            $display("FAIL step_with_trig: got lamp=%b hit=%b ev=%b drop=%0d, want 0110 0001 1 1",
                     lamp_state, hit_mask, eval_valid, drop_cnt);
        else passed++;
    endtask

    task automatic test_coalesce();
        logic [LC-1:0] tr_vec [5];
        logic [LC-1:0] lamp_exp;
        tr_vec   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0011};
        lamp_exp = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, tr_vec[i], 1'b0);
            lamp_exp = lamp_exp ^ tr_vec[i];
            total++;
            if ({lamp_state, hit_mask, eval_valid} !== {lamp_exp, tr_vec[i], 1'b1})
                $display("FAIL coalesce[%0d]: got lamp=%b hit=%b ev=%b, want %b %b 1",
                         i, lamp_state, hit_mask, eval_valid, lamp_exp, tr_vec[i]);
            else passed++;
        end
        // Handshake with no new toggles drops eval_valid
        cycle(1'b0, 4'b0000, 1'b1);
        total++;
        if ({lamp_state, eval_valid} !== {4'b1010, 1'b0})
            $display("FAIL handshake_clear: got lamp=%b ev=%b, want 1010 0", lamp_state, eval_valid);
        else passed++;
        // eval_ready while idle has no effect
        cycle(1'b0, 4'b0000, 1'b1);
        total++;
        if (eval_valid !== 1'b0)
            $display("FAIL ready_idle: got ev=%b, want 0", eval_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 4'b0001, 1'b0);
        total++;
        if ({lamp_state, eval_valid} !== {4'b1011, 1'b1})
            $display("FAIL b2b_arm: got lamp=%b ev=%b, want 1011 1", lamp_state, eval_valid);
        else passed++;
        // Handshake cycle that also carries a new accepted toggle
        cycle(1'b1, 4'b0100, 1'b1);
        total++;
        if ({lamp_state, eval_valid} !== {4'b1111, 1'b1})
            $display("FAIL b2b_handshake_new: got lamp=%b ev=%b, want 1111 1", lamp_state, eval_valid);
        else passed++;
        cycle(1'b0, 4'b0000, 1'b1);
        total++;
        if (eval_valid !== 1'b0)
            $display("FAIL b2b_clear: got ev=%b, want 0", eval_valid);
        else passed++;
    endtask

    task automatic test_net_zero();
        cycle(1'b1, 4'b0001, 1'b0);
        cycle(1'b1, 4'b0001, 1'b0);
        total++;
        if ({lamp_state, eval_valid} !== {4'b1111, 1'b1})
            $display("FAIL net_zero: got lamp=%b ev=%b, want 1111 1", lamp_state, eval_valid);
        else passed++;
        cycle(1'b0, 4'b0000, 1'b1);
        total++;
        if (eval_valid !== 1'b0)
            $display("FAIL net_zero_clear: got ev=%b, want 0", eval_valid);
        else passed++;
    endtask

    task automatic test_saturation();
        int cnt_exp;
        cycle(1'b1, 4'b1111, 1'b0);
        total++;
        if ({lamp_state, hit_mask, eval_valid, drop_cnt} !== {4'b0000, 4'b1111, 1'b1, 4'd1})
            $display("FAIL sat_first: got lamp=%b hit=%b ev=%b drop=%0d, want 0000 1111 1 1",
                     lamp_state, hit_mask, eval_valid, drop_cnt);
        else passed++;
        cnt_exp = 1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 4'b1111, 1'b0);
            cnt_exp = (cnt_exp + 4 > 15) ? 15 : cnt_exp + 4;
            total++;
            if ({lamp_state, drop_cnt} !== {4'b0000, 4'(cnt_exp)})
                $display("FAIL sat[%0d]: got lamp=%b drop=%0d, want 0000 %0d",
                         i, lamp_state, drop_cnt, cnt_exp);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        step_start = 1'b0;
        trig       = 4'b0000;
        eval_ready = 1'b0;
        #2;
        logic_reset_n = 1'b0;
        #1;
        total++;
        if ({lamp_state, hit_mask, eval_valid, drop_cnt} !== 13'b0000_0000_0_0000)
            $display("FAIL async_reset: got lamp=%b hit=%b ev=%b drop=%0d, want 0000 0000 0 0",
                     lamp_state, hit_mask, eval_valid, drop_cnt);
        else passed++;
        @(negedge clk);
        logic_reset_n = 1'b1;
        cycle(1'b0, 4'b1000, 1'b0);
        total++;
        if ({lamp_state, hit_mask, eval_valid, drop_cnt} !== {4'b1000, 4'b1000, 1'b1, 4'd0})
            $display("FAIL after_reset: got lamp=%b hit=%b ev=%b drop=%0d, want 1000 1000 1 0",
                     lamp_state, hit_mask, eval_valid, drop_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_repeat_hit();
        test_step_with_trig();
        test_coalesce();
        test_back_to_back();
        test_net_zero();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
